// File: rtl/prio_enc_arb_pkg.sv
// rtl/prio_enc_arb_pkg.sv - shared types, mode constants and width helper for prio_enc_arb
package prio_enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Never returns 0 so a 2-entry arbiter still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_arb_if.sv
// rtl/prio_enc_arb_if.sv - request/grant bundle between requesters and prio_enc_arb
interface prio_enc_arb_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = idx_width(N);

  logic         en;
  logic         mode_rr;
  logic [N-1:0] req;
  logic         release_i;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic         timeout_o;

  modport master (
    output en, mode_rr, req, release_i,
    input  gnt_valid, gnt_idx, gnt_onehot, timeout_o
  );

  modport slave (
    input  en, mode_rr, req, release_i,
    output gnt_valid, gnt_idx, gnt_onehot, timeout_o
  );

endinterface

// File: rtl/prio_enc_arb_pick.sv
// rtl/prio_enc_arb_pick.sv - combinational winner pick: rotate, highest-bit select, un-rotate
module prio_pick_n
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  int           base;
  int           k;
  int           hi;

  // rot[N-1] maps to req[start-1], so the highest set bit of rot is the
  // first hit of a descending search that wraps around at start.
  always_comb begin
    rot   = '0;
    base  = (mode == MODE_RR) ? int'(start) : 0;
    k     = 0;
    hi    = 0;
    found = |req;
    for (int j = 0; j < N; j++) begin
      k = j + base;
      if (k >= N) k = k - N;
      rot[j] = req[k[W-1:0]];
    end
    for (int j = 0; j < N; j++) begin
      if (rot[j]) hi = j;
    end
    k = hi + base;
    if (k >= N) k = k - N;
    idx = k[W-1:0];
  end

endmodule

// File: rtl/prio_enc_arb.sv
// rtl/prio_enc_arb.sv - registered fixed/round-robin arbiter; optional grant timeout via PRIO_ENC_ARB_TIMEOUT_EN
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int W        = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  prio_enc_arb_if.slave   bus
);

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_GRANT = ST_GRANT;

  if (N < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("prio_enc_arb: N and MAX_HOLD must both be at least 2");
  end

  logic [0:0]   state;
  logic [W-1:0] ptr;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         grant_exit;
  logic         hold_done;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;

  prio_pick_n #(.N(N)) u_pick (
    .req   (bus.req),
    .start (ptr),
    .mode  (bus.mode_rr ? MODE_RR : MODE_FIXED),
    .idx   (win_idx),
    .found (win_found)
  );

  // A withdrawn request ends the grant exactly like an explicit release.
  assign grant_exit = bus.release_i || !bus.req[idx_q] || !bus.en;

`ifdef PRIO_ENC_ARB_TIMEOUT_EN
  localparam int HW = idx_width(MAX_HOLD);

  logic [HW-1:0] hold_q;
  logic          timeout_q;

  assign hold_done = (state == S_GRANT) && (hold_q == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= hold_done && !grant_exit;
      if (state == S_GRANT && !grant_exit && !hold_done) begin
        hold_q <= hold_q + 1'b1;
      end else begin
        hold_q <= '0;
      end
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign hold_done     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.en && win_found) begin
            state    <= S_GRANT;
            valid_q  <= 1'b1;
            idx_q    <= win_idx;
            onehot_q <= N'(1) << win_idx;
            ptr      <= win_idx;
          end
        end
        default: begin
          if (grant_exit || hold_done) begin
            state    <= S_IDLE;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb/tb_prio_enc_arb.sv - directed and randomized checks of prio_enc_arb against a behavioural model
module tb_prio_enc_arb;
  import prio_enc_pkg::*;

  localparam int N = 8;
`ifdef PRIO_ENC_ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
  localparam bit TO_EN    = 1'b1;
`else
  localparam int MAX_HOLD = 16;
  localparam bit TO_EN    = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prio_enc_arb_if #(.N(N)) bus ();

  prio_enc_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit m_valid;
  bit m_to;
  int m_idx;
  int m_ptr;
  int m_hold;

  int rr_exp[4] = '{7, 4, 1, 7};
  int cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [N-1:0] r, input bit rr, input int p);
    int i;
    if (!rr) begin
      for (int b = N - 1; b >= 0; b--) if (r[b]) return b;
    end else begin
      for (int s = 1; s <= N; s++) begin
        i = (p - s + N) % N;
        if (r[i]) return i;
      end
    end
    return 0;
  endfunction

  task automatic model_step();
    bit ex;
    bit tmo;
    if (!rst_n) begin
      m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else begin
      m_to = 0;
      if (!m_valid) begin
        if (bus.en && bus.req != '0) begin
          m_idx   = ref_pick(bus.req, bus.mode_rr, m_ptr);
          m_ptr   = m_idx;
          m_valid = 1;
          m_hold  = 0;
        end
      end else begin
        ex  = bus.release_i || !bus.req[m_idx] || !bus.en;
        tmo = TO_EN && (m_hold == MAX_HOLD - 1);
        if (ex || tmo) begin
          m_valid = 0;
          m_idx   = 0;
          m_to    = !ex && tmo;
        end else begin
          m_hold++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("gnt_valid",  bus.gnt_valid, m_valid);
    check("gnt_idx",    bus.gnt_idx, m_valid ? m_idx : 0);
    check("gnt_onehot", bus.gnt_onehot, m_valid ? (32'd1 << m_idx) : 32'd0);
    check("timeout_o",  bus.timeout_o, m_to);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [N-1:0] r, input bit e, input bit rel, input bit mr, input bit rs);
    bus.req       = r;
    bus.en        = e;
    bus.release_i = rel;
    bus.mode_rr   = mr;
    rst_n         = rs;
  endtask

  initial begin
    drive('0, 0, 0, MODE_FIXED, 0);
    cyc(); cyc();
    check("rst_valid", bus.gnt_valid, 0);
    check("rst_onehot", bus.gnt_onehot, 0);

    drive(8'hFF, 0, 0, MODE_FIXED, 1);
    repeat (3) cyc();
    check("en0_idle", bus.gnt_valid, 0);

    drive(8'h24, 1, 0, MODE_FIXED, 1); cyc();
    check("fix_idx", bus.gnt_idx, 5);
    check("fix_onehot", bus.gnt_onehot, 8'h20);
    drive(8'h24, 1, 1, MODE_FIXED, 1); cyc();
    check("fix_release", bus.gnt_valid, 0);
    drive(8'h24, 1, 0, MODE_FIXED, 1); cyc();
    check("fix_regrant", bus.gnt_idx, 5);

    drive('0, 1, 0, MODE_RR, 0); cyc();
    for (int k = 0; k < 4; k++) begin
      drive(8'h92, 1, 0, MODE_RR, 1); cyc();
      check("rr_seq", bus.gnt_idx, rr_exp[k]);
      drive(8'h92, 1, 1, MODE_RR, 1); cyc();
      check("rr_bubble", bus.gnt_valid, 0);
    end

    drive(8'h08, 1, 0, MODE_FIXED, 1); cyc();
    check("wd_idx", bus.gnt_idx, 3);
    drive(8'h00, 1, 0, MODE_FIXED, 1); cyc();
    check("wd_exit", bus.gnt_valid, 0);

    drive('0, 1, 0, MODE_RR, 0); cyc();
    drive(8'h41, 1, 0, MODE_RR, 1); cyc();
    check("abort_idx", bus.gnt_idx, 6);
    drive(8'h41, 0, 0, MODE_RR, 1); cyc();
    check("abort_exit", bus.gnt_valid, 0);
    drive(8'h41, 1, 0, MODE_RR, 1); cyc();
    check("abort_skip", bus.gnt_idx, 0);

    drive(8'h41, 1, 1, MODE_RR, 1); cyc();
    drive(8'h41, 1, 0, MODE_RR, 1); cyc();
    check("pre_rst_idx", bus.gnt_idx, 6);
    drive(8'h41, 1, 0, MODE_RR, 0); cyc();
    check("midrst_valid", bus.gnt_valid, 0);
    check("midrst_idx", bus.gnt_idx, 0);
    drive(8'h41, 1, 0, MODE_RR, 1); cyc();
    check("rst_ptr", bus.gnt_idx, 6);
    drive(8'h41, 1, 0, MODE_FIXED, 1); cyc();
    check("mode_hold", bus.gnt_idx, 6);

    drive(8'h41, 1, 1, MODE_FIXED, 1); cyc();
    drive(8'h04, 1, 0, MODE_FIXED, 1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (bus.gnt_valid) cnt++;
    end
    check("hold_len", cnt, TO_EN ? 4 : 5);
    check("to_pulse", bus.timeout_o, TO_EN);
    repeat (8) cyc();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.en        = ($urandom_range(0, 15) != 0);
      bus.release_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.mode_rr = ~bus.mode_rr;
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
